// File: rtl/matmul_seq_engine.sv
// Sequential matrix-multiply engine.
// Computes C[m][n] = sum_k dot(A[m*kc+k], B[n*kc+k]) where every memory word
// holds LANES signed operands. A is row-major in chunks, B column-major in chunks.
// Each result is arithmetically right-shifted by cfg_shift, saturated to
// DATA_WIDTH bits and written at address m*cfg_n+n through a ready handshake.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start, abort        : job start (IDLE only) and immediate cancel
//   busy, done, err     : status (done is a one-cycle pulse, err is sticky per job)
//   cfg_m/n/kc/shift    : job geometry and result shift, latched on start
//   a_en/a_addr/a_data  : matrix A read port, read latency 1
//   b_en/b_addr/b_data  : matrix B read port, read latency 1
//   out_we/out_addr/out_data/out_ready : result write port with handshake
module matmul_seq_engine #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 8,
    parameter int DIM_W      = 6,
    parameter int IN_ADDR_W  = 12,
    parameter int OUT_ADDR_W = 12
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    input  logic [DIM_W-1:0]            cfg_m,
    input  logic [DIM_W-1:0]            cfg_n,
    input  logic [DIM_W-1:0]            cfg_kc,
    input  logic [4:0]                  cfg_shift,
    output logic                        a_en,
    output logic [IN_ADDR_W-1:0]        a_addr,
    input  logic [LANES*DATA_WIDTH-1:0] a_data,
    output logic                        b_en,
    output logic [IN_ADDR_W-1:0]        b_addr,
    input  logic [LANES*DATA_WIDTH-1:0] b_data,
    output logic                        out_we,
    output logic [OUT_ADDR_W-1:0]       out_addr,
    output logic [DATA_WIDTH-1:0]       out_data,
    input  logic                        out_ready
);

    localparam int L         = $clog2(LANES);
    localparam int PW        = 2 * DATA_WIDTH;
    localparam int TW        = PW + L;
    localparam int ACC_W     = PW + L + DIM_W;
    localparam int DRAIN_LEN = 2 + L;
    localparam int DCNT_W    = $clog2(DRAIN_LEN + 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_WIDTH - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WRITE, DONE} state_t;

    state_t                    state_r, state_s;
    logic [DIM_W-1:0]          m_r, m_s, n_r, n_s, k_r, k_s;
    logic [DCNT_W-1:0]         dcnt_r, dcnt_s;
    logic [DIM_W-1:0]          cm_r, cn_r, ckc_r;
    logic [4:0]                shift_r;
    logic                      err_r, err_s;
    logic                      a_en_r, a_en_s, out_we_r, out_we_s;
    logic                      busy_r, busy_s, done_r, done_s;
    logic                      latch_s, acc_clr_s;
    logic                      rd_v_r;
    logic signed [PW-1:0]      prod_r [LANES];
    // Tree nodes packed level by level: level s starts at LANES-(LANES>>s).
    logic signed [TW-1:0]      tree_r [LANES-1];
    logic signed [ACC_W-1:0]   acc_r;

    // Arithmetic right shift (floor) followed by saturation to DATA_WIDTH.
    function automatic logic [DATA_WIDTH-1:0] shift_sat(input logic signed [ACC_W-1:0] v,
                                                        input logic [4:0] sh);
        logic signed [ACC_W-1:0] s;
        s = v >>> sh;
        if (s > SAT_MAX) begin
            return SAT_MAX[DATA_WIDTH-1:0];
        end else if (s < SAT_MIN) begin
            return SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            return s[DATA_WIDTH-1:0];
        end
    endfunction

    // Next-state, counter and registered-strobe logic.
    always_comb begin
        state_s   = state_r;
        m_s       = m_r;
        n_s       = n_r;
        k_s       = k_r;
        dcnt_s    = dcnt_r;
        err_s     = err_r;
        a_en_s    = 1'b0;
        out_we_s  = 1'b0;
        done_s    = 1'b0;
        busy_s    = 1'b1;
        latch_s   = 1'b0;
        acc_clr_s = 1'b0;
        if (abort) begin
            state_s = IDLE;
            busy_s  = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    busy_s = 1'b0;
                    if (start) begin
                        latch_s   = 1'b1;
                        acc_clr_s = 1'b1;
                        busy_s    = 1'b1;
                        m_s       = {DIM_W{1'b0}};
                        n_s       = {DIM_W{1'b0}};
                        k_s       = {DIM_W{1'b0}};
                        if ((cfg_m == {DIM_W{1'b0}}) || (cfg_n == {DIM_W{1'b0}}) ||
                            (cfg_kc == {DIM_W{1'b0}})) begin
                            state_s = DONE;
                            err_s   = 1'b1;
                            done_s  = 1'b1;
                        end else begin
                            state_s = ISSUE;
                            err_s   = 1'b0;
                            a_en_s  = 1'b1;
                        end
                    end else begin
                        state_s = IDLE;
                    end
                end
                ISSUE: begin
                    if (k_r == ckc_r - DIM_W'(1)) begin
                        k_s     = {DIM_W{1'b0}};
                        dcnt_s  = {DCNT_W{1'b0}};
                        state_s = DRAIN;
                    end else begin
                        k_s    = k_r + DIM_W'(1);
                        a_en_s = 1'b1;
                    end
                end
                DRAIN: begin
                    // Last accumulate lands on the same edge that enters WRITE.
                    if (dcnt_r == DCNT_W'(DRAIN_LEN - 1)) begin
                        state_s  = WRITE;
                        out_we_s = 1'b1;
                    end else begin
                        dcnt_s = dcnt_r + DCNT_W'(1);
                    end
                end
                WRITE: begin
                    if (out_ready) begin
                        acc_clr_s = 1'b1;
                        if (n_r == cn_r - DIM_W'(1)) begin
                            n_s = {DIM_W{1'b0}};
                            if (m_r == cm_r - DIM_W'(1)) begin
                                state_s = DONE;
                                done_s  = 1'b1;
                            end else begin
                                m_s     = m_r + DIM_W'(1);
                                state_s = ISSUE;
                                a_en_s  = 1'b1;
                            end
                        end else begin
                            n_s     = n_r + DIM_W'(1);
                            state_s = ISSUE;
                            a_en_s  = 1'b1;
                        end
                    end else begin
                        out_we_s = 1'b1;
                    end
                end
                DONE: begin
                    state_s = IDLE;
                    busy_s  = 1'b0;
                end
                default: begin
                    state_s = IDLE;
                    busy_s  = 1'b0;
                end
            endcase
        end
    end

    // Control state, counters, latched configuration and registered strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            m_r      <= {DIM_W{1'b0}};
            n_r      <= {DIM_W{1'b0}};
            k_r      <= {DIM_W{1'b0}};
            dcnt_r   <= {DCNT_W{1'b0}};
            cm_r     <= {DIM_W{1'b0}};
            cn_r     <= {DIM_W{1'b0}};
            ckc_r    <= {DIM_W{1'b0}};
            shift_r  <= 5'd0;
            err_r    <= 1'b0;
            a_en_r   <= 1'b0;
            out_we_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            m_r      <= m_s;
            n_r      <= n_s;
            k_r      <= k_s;
            dcnt_r   <= dcnt_s;
            err_r    <= err_s;
            a_en_r   <= a_en_s;
            out_we_r <= out_we_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            if (latch_s) begin
                cm_r    <= cfg_m;
                cn_r    <= cfg_n;
                ckc_r   <= cfg_kc;
                shift_r <= cfg_shift;
            end else begin
                shift_r <= shift_r;
            end
        end
    end

    // Product and adder-tree pipeline; flushed on abort so a later job starts clean.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            rd_v_r <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                prod_r[i] <= {PW{1'b0}};
            end
            for (int i = 0; i < LANES - 1; i++) begin
                tree_r[i] <= {TW{1'b0}};
            end
        end else begin
            rd_v_r <= a_en_r;
            for (int i = 0; i < LANES; i++) begin
                if (rd_v_r) begin
                    prod_r[i] <= $signed(a_data[i*DATA_WIDTH +: DATA_WIDTH]) *
                                 $signed(b_data[i*DATA_WIDTH +: DATA_WIDTH]);
                end else begin
                    prod_r[i] <= {PW{1'b0}};
                end
            end
            for (int j = 0; j < LANES / 2; j++) begin
                tree_r[j] <= TW'(prod_r[2*j]) + TW'(prod_r[2*j+1]);
            end
            for (int s = 1; s < L; s++) begin
                for (int j = 0; j < (LANES >> (s + 1)); j++) begin
                    tree_r[LANES - (LANES >> s) + j] <=
                        tree_r[LANES - (LANES >> (s - 1)) + 2*j] +
                        tree_r[LANES - (LANES >> (s - 1)) + 2*j + 1];
                end
            end
        end
    end

    // Accumulator: idle cycles add zero because invalid products are forced to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (acc_clr_s) begin
            acc_r <= {ACC_W{1'b0}};
        end else begin
            acc_r <= acc_r + ACC_W'(tree_r[LANES-2]);
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign err      = err_r;
    assign a_en     = a_en_r;
    assign b_en     = a_en_r;
    assign out_we   = out_we_r;
    assign a_addr   = IN_ADDR_W'(m_r) * IN_ADDR_W'(ckc_r) + IN_ADDR_W'(k_r);
    assign b_addr   = IN_ADDR_W'(n_r) * IN_ADDR_W'(ckc_r) + IN_ADDR_W'(k_r);
    assign out_addr = OUT_ADDR_W'(m_r) * OUT_ADDR_W'(cn_r) + OUT_ADDR_W'(n_r);
    assign out_data = shift_sat(acc_r, shift_r);

endmodule

// File: tb/tb_matmul_seq_engine.sv
// Directed bench for matmul_seq_engine with LANES=4, DATA_WIDTH=16.
module tb_matmul_seq_engine;

    localparam int DW = 16;
    localparam int LN = 4;
    localparam int DIM_W = 6;
    localparam int AW = 12;

    logic clk = 1'b0;
    logic rst, start, abort, out_ready;
    logic busy, done, err;
    logic [DIM_W-1:0] cfg_m, cfg_n, cfg_kc;
    logic [4:0] cfg_shift;
    logic a_en, b_en, out_we;
    logic [AW-1:0] a_addr, b_addr, out_addr;
    logic [LN*DW-1:0] a_data, b_data;
    logic [DW-1:0] out_data;

    logic [LN*DW-1:0] a_mem [64];
    logic [LN*DW-1:0] b_mem [64];

    int n_checks = 0;
    int n_fail = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    logic [AW-1:0] wa_q [$];
    logic [DW-1:0] wd_q [$];

    always #5 clk = ~clk;

    matmul_seq_engine #(.DATA_WIDTH(DW), .LANES(LN), .DIM_W(DIM_W),
                        .IN_ADDR_W(AW), .OUT_ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(busy), .done(done), .err(err),
        .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_kc(cfg_kc), .cfg_shift(cfg_shift),
        .a_en(a_en), .a_addr(a_addr), .a_data(a_data),
        .b_en(b_en), .b_addr(b_addr), .b_data(b_data),
        .out_we(out_we), .out_addr(out_addr), .out_data(out_data),
        .out_ready(out_ready)
    );

    // Latency-1 memories plus write/read/done monitor.
    always @(posedge clk) begin
        if (a_en) a_data <= a_mem[a_addr];
        if (b_en) b_data <= b_mem[b_addr];
        if (out_we && out_ready) begin
            wa_q.push_back(out_addr);
            wd_q.push_back(out_data);
        end
        if (a_en) rd_cnt++;
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [LN*DW-1:0] pack4(input int x0, input int x1, input int x2, input int x3);
        return {16'(x3), 16'(x2), 16'(x1), 16'(x0)};
    endfunction

    function automatic logic [DW-1:0] ref_dot(input int mi, input int ni, input int kc, input int sh);
        longint s = 0;
        for (int k = 0; k < kc; k++)
            for (int l = 0; l < LN; l++)
                s += longint'($signed(a_mem[mi*kc+k][l*DW +: DW])) *
                     longint'($signed(b_mem[ni*kc+k][l*DW +: DW]));
        s = s >>> sh;
        if (s > 32767) return 16'h7fff;
        else if (s < -32768) return 16'h8000;
        else return s[15:0];
    endfunction

    // Pulse start so that it is sampled on the next edge; returns #1 after that edge.
    task automatic start_job(input int m, input int n, input int kc, input int sh);
        @(negedge clk);
        wa_q.delete();
        wd_q.delete();
        rd_cnt = 0;
        done_cnt = 0;
        cfg_m = DIM_W'(m);
        cfg_n = DIM_W'(n);
        cfg_kc = DIM_W'(kc);
        cfg_shift = 5'(sh);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (done) ok = 1'b1;
        end
        check("done_within_budget", 64'(ok), 64'd1);
    endtask

    task automatic run_single(input string tag, input int sh, input logic [DW-1:0] exp);
        start_job(1, 1, 1, sh);
        wait_done(50);
        check({tag, "_nwr"}, 64'(wd_q.size()), 64'd1);
        if (wd_q.size() > 0) check(tag, 64'(wd_q[0]), 64'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        cfg_m = '0; cfg_n = '0; cfg_kc = '0; cfg_shift = '0;
        a_data = '0; b_data = '0;
        for (int i = 0; i < 64; i++) begin
            a_mem[i] = '0;
            b_mem[i] = '0;
        end
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_aen", 64'(a_en), 64'd0);
        check("rst_we", 64'(out_we), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        rst = 1'b0;

        // Basic timeline: a_en cycle 1, out_we cycle 6, done cycle 7.
        a_mem[0] = pack4(1, 2, 3, 4);
        b_mem[0] = pack4(5, 6, 7, 8);
        start_job(1, 1, 1, 0);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            check($sformatf("t_aen_c%0d", c), 64'(a_en), 64'(c == 1));
            check($sformatf("t_we_c%0d", c), 64'(out_we), 64'(c == 6));
            check($sformatf("t_done_c%0d", c), 64'(done), 64'(c == 7));
            if (c == 6) begin
                check("t_addr", 64'(out_addr), 64'd0);
                check("t_data", 64'(out_data), 64'd70);
            end
        end
        check("t_nwr", 64'(wd_q.size()), 64'd1);

        // Saturation and shift.
        a_mem[0] = pack4(32767, 32767, 32767, 32767);
        b_mem[0] = pack4(32767, 32767, 32767, 32767);
        run_single("sat_pos", 0, 16'h7fff);
        a_mem[0] = pack4(-32767, -32767, -32767, -32767);
        run_single("sat_neg", 0, 16'h8000);
        a_mem[0] = pack4(32767, 32767, 32767, 32767);
        run_single("shift30", 30, 16'h0003);

        // 2x3 result, kc=2, pseudo-random small operands.
        for (int i = 0; i < 6; i++) begin
            a_mem[i] = pack4($urandom_range(0, 2000) - 1000, $urandom_range(0, 2000) - 1000,
                             $urandom_range(0, 2000) - 1000, $urandom_range(0, 2000) - 1000);
            b_mem[i] = pack4($urandom_range(0, 2000) - 1000, $urandom_range(0, 2000) - 1000,
                             $urandom_range(0, 2000) - 1000, $urandom_range(0, 2000) - 1000);
        end
        start_job(2, 3, 2, 8);
        wait_done(500);
        check("mm_nwr", 64'(wd_q.size()), 64'd6);
        check("mm_nrd", 64'(rd_cnt), 64'd12);
        for (int i = 0; i < wd_q.size() && i < 6; i++) begin
            check($sformatf("mm_addr%0d", i), 64'(wa_q[i]), 64'(i));
            check($sformatf("mm_data%0d", i), 64'(wd_q[i]), 64'(ref_dot(i / 3, i % 3, 2, 8)));
        end

        // Backpressure: out_ready low for 5 WRITE cycles.
        a_mem[0] = pack4(1, 2, 3, 4);
        b_mem[0] = pack4(5, 6, 7, 8);
        out_ready = 1'b0;
        start_job(1, 1, 1, 0);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 50 && !seen; i++) begin
                @(negedge clk);
                if (out_we) seen = 1'b1;
            end
            check("bp_we_seen", 64'(seen), 64'd1);
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check($sformatf("bp_we%0d", i), 64'(out_we), 64'd1);
            check($sformatf("bp_addr%0d", i), 64'(out_addr), 64'd0);
            check($sformatf("bp_data%0d", i), 64'(out_data), 64'd70);
        end
        @(negedge clk);
        check("bp_we_last", 64'(out_we), 64'd1);
        out_ready = 1'b1;
        wait_done(20);
        check("bp_nwr", 64'(wd_q.size()), 64'd1);
        check("bp_nrd", 64'(rd_cnt), 64'd1);

        // Abort in the 2nd ISSUE cycle.
        start_job(1, 1, 4, 0);
        @(negedge clk);
        check("ab_issue1", 64'(a_en), 64'd1);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("ab_busy", 64'(busy), 64'd0);
        check("ab_aen", 64'(a_en), 64'd0);
        repeat (20) @(negedge clk);
        check("ab_nwr", 64'(wd_q.size()), 64'd0);
        check("ab_done", 64'(done_cnt), 64'd0);

        // Zero kc: error and done, no memory activity; next legal start clears err.
        start_job(1, 1, 0, 0);
        @(negedge clk);
        check("z_err", 64'(err), 64'd1);
        check("z_done", 64'(done), 64'd1);
        repeat (5) @(negedge clk);
        check("z_done_once", 64'(done_cnt), 64'd1);
        check("z_nrd", 64'(rd_cnt), 64'd0);
        check("z_nwr", 64'(wd_q.size()), 64'd0);
        check("z_err_hold", 64'(err), 64'd1);
        start_job(1, 1, 1, 0);
        @(negedge clk);
        check("z_err_clr", 64'(err), 64'd0);
        wait_done(50);

        // Reset in the middle of a job.
        start_job(2, 2, 3, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mr_busy", 64'(busy), 64'd0);
        check("mr_aen", 64'(a_en), 64'd0);
        check("mr_we", 64'(out_we), 64'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("mr_nwr", 64'(wd_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
